// File: rtl/tdm_demux16_pkg.sv
// Shared TDM frame constants, also used by the 16:1 mux blocks that produce the serial stream.
// Holds the slot count, slot index width and lock-state encodings.
package tdm_demux16_pkg;
   localparam int N_CH  = 16;
   localparam int SEL_W = 4;

   localparam logic [0:0] ST_UNLOCKED = 1'b0;
   localparam logic [0:0] ST_LOCKED   = 1'b1;
endpackage

// File: rtl/tdm_demux16_demux1x16.sv
// Slot decoder: turns a slot index plus enable into a one-hot shadow write enable.
// Purely combinational, zero latency; there is no backpressure.
module demux1x16 #(
   parameter int N_CH  = tdm_demux16_pkg::N_CH,
   parameter int SEL_W = tdm_demux16_pkg::SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [N_CH-1:0]  we
);

   always_comb begin
      we = '0;
      if (en) we[sel] = 1'b1;
   end

endmodule

// File: rtl/tdm_demux16.sv
// Serial TDM to parallel frame demultiplexer with sync-based frame lock.
// A frame appears on out_data one cycle after its last slot is sampled; the block cannot stall its input.
module tdm_demux16 #(
   parameter int N_CH  = tdm_demux16_pkg::N_CH,
   parameter int SEL_W = tdm_demux16_pkg::SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_bit,
   input  logic             in_valid,
   input  logic             in_sync,
   output logic [N_CH-1:0]  out_data,
   output logic             out_valid,
   output logic [SEL_W-1:0] slot,
   output logic             locked,
   output logic             sync_err
);
   import tdm_demux16_pkg::*;

   logic [0:0]       state;
   logic [N_CH-1:0]  shadow;
   logic [N_CH-1:0]  we;
   logic [SEL_W-1:0] wr_sel;
   logic             wr_en;
   logic             resync;
   logic             frame_end;

   assign locked = (state == ST_LOCKED);

   // A sync beat always lands in slot 0, whatever the counter says.
   assign wr_en     = in_valid & (locked | in_sync);
   assign wr_sel    = in_sync ? '0 : slot;
   assign resync    = in_valid & in_sync & locked & (slot != '0);
   assign frame_end = in_valid & locked & ~in_sync & (slot == SEL_W'(N_CH - 1));

   demux1x16 #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_demux (
      .sel (wr_sel),
      .en  (wr_en),
      .we  (we)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_UNLOCKED;
         slot      <= '0;
         shadow    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         out_valid <= frame_end;
         sync_err  <= resync;
         if (wr_en) begin
            // A mid-frame sync drops every bit gathered so far.
            for (int i = 0; i < N_CH; i++) begin
               if (we[i])       shadow[i] <= in_bit;
               else if (resync) shadow[i] <= 1'b0;
            end
            state <= ST_LOCKED;
            if (in_sync)        slot <= SEL_W'(1);
            else if (frame_end) slot <= '0;
            else                slot <= slot + SEL_W'(1);
         end
         if (frame_end) out_data <= {in_bit, shadow[N_CH-2:0]};
      end
   end

endmodule

// File: tb/tb_tdm_demux16.sv
// Randomized and directed bench for tdm_demux16 against a slot-array reference model.
module tb_tdm_demux16;
   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_bit = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_sync = 1'b0;
   logic [15:0] out_data;
   logic        out_valid;
   logic [3:0]  slot;
   logic        locked;
   logic        sync_err;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;
   int pulse_cyc[$];

   // reference model state
   logic        m_locked;
   int          m_slot;
   logic [15:0] m_frame;
   logic [15:0] m_data;
   logic        m_ov;
   logic        m_err;

   always #5 clk = ~clk;

   tdm_demux16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_sync   (in_sync),
      .out_data  (out_data),
      .out_valid (out_valid),
      .slot      (slot),
      .locked    (locked),
      .sync_err  (sync_err)
   );

   task automatic step(input logic r, input logic v, input logic s, input logic b);
      rst = r; in_valid = v; in_sync = s; in_bit = b;
      @(posedge clk);
      #1;
      cycle++;
      if (out_valid) pulse_cyc.push_back(cycle);
      m_ov  = 1'b0;
      m_err = 1'b0;
      if (r) begin
         m_locked = 1'b0; m_slot = 0; m_frame = '0; m_data = '0;
      end else if (v) begin
         if (s) begin
            if (m_locked && m_slot != 0) m_err = 1'b1;
            if (m_err || !m_locked) m_frame = '0;
            m_frame[0] = b;
            m_slot = 1;
            m_locked = 1'b1;
         end else if (m_locked) begin
            m_frame[m_slot] = b;
            if (m_slot == N - 1) begin
               m_data = m_frame;
               m_ov = 1'b1;
               m_slot = 0;
            end else begin
               m_slot++;
            end
         end
      end
   endtask

   task automatic send_frame(input logic [15:0] f, input bit sync_first, input int gap);
      for (int i = 0; i < N; i++) begin
         step(1'b0, 1'b1, logic'(sync_first && i == 0), f[i]);
         for (int g = 0; g < gap; g++) step(1'b0, 1'b0, logic'($urandom_range(1)), logic'($urandom_range(1)));
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      pulse_cyc.delete();
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      vectors += 5;
      if (out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data got %h want 0000", out_data); end
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      if (slot !== 4'd0) begin miscompares++; $display("FAIL reset_slot got %0d want 0", slot); end
      if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %b want 0", locked); end
      if (sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
   endtask

   task automatic test_known_frame();
      do_reset();
      send_frame(16'hAF0D, 1'b1, 0);
      vectors += 5;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL known_valid got %b want 1", out_valid); end
      if (out_data !== 16'hAF0D) begin miscompares++; $display("FAIL known_data got %h want AF0D", out_data); end
      if (out_data !== m_data) begin miscompares++; $display("FAIL known_model got %h want %h", out_data, m_data); end
      if (slot !== 4'd0) begin miscompares++; $display("FAIL known_slot got %0d want 0", slot); end
      if (pulse_cyc.size() != 1) begin miscompares++; $display("FAIL known_pulses got %0d want 1", pulse_cyc.size()); end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      vectors += 2;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL known_valid_drop got %b want 0", out_valid); end
      if (out_data !== 16'hAF0D) begin miscompares++; $display("FAIL known_hold got %h want AF0D", out_data); end
   endtask

   task automatic test_presync();
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      vectors += 2;
      if (slot !== 4'd0) begin miscompares++; $display("FAIL presync_slot got %0d want 0", slot); end
      if (locked !== 1'b0) begin miscompares++; $display("FAIL presync_locked got %b want 0", locked); end
      send_frame(16'h0000, 1'b1, 0);
      vectors += 3;
      if (out_data !== 16'h0000) begin miscompares++; $display("FAIL presync_data got %h want 0000", out_data); end
      if (locked !== 1'b1) begin miscompares++; $display("FAIL presync_lock got %b want 1", locked); end
      if (pulse_cyc.size() != 1) begin miscompares++; $display("FAIL presync_pulses got %0d want 1", pulse_cyc.size()); end
   endtask

   task automatic test_gaps();
      logic [15:0] f;
      f = 16'($urandom);
      do_reset();
      send_frame(f, 1'b1, 3);
      vectors += 2;
      if (out_data !== f) begin miscompares++; $display("FAIL gaps_data got %h want %h", out_data, f); end
      if (pulse_cyc.size() != 1) begin miscompares++; $display("FAIL gaps_pulses got %0d want 1", pulse_cyc.size()); end
   endtask

   task automatic test_mid_sync();
      logic [15:0] f0, f1;
      f0 = 16'($urandom) | 16'hFFFE;
      f1 = 16'($urandom);
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, logic'(i == 0), f0[i]);
      step(1'b0, 1'b1, 1'b1, f1[0]);
      vectors += 3;
      if (sync_err !== 1'b1) begin miscompares++; $display("FAIL midsync_err got %b want 1", sync_err); end
      if (slot !== 4'd1) begin miscompares++; $display("FAIL midsync_slot got %0d want 1", slot); end
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midsync_valid got %b want 0", out_valid); end
      for (int i = 1; i < N; i++) begin
         step(1'b0, 1'b1, 1'b0, f1[i]);
         vectors++;
         if (sync_err !== 1'b0) begin miscompares++; $display("FAIL midsync_err_once got %b want 0", sync_err); end
      end
      vectors += 2;
      if (out_data !== f1) begin miscompares++; $display("FAIL midsync_data got %h want %h", out_data, f1); end
      if (pulse_cyc.size() != 1) begin miscompares++; $display("FAIL midsync_pulses got %0d want 1", pulse_cyc.size()); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, logic'(i == 0), 1'b1);
      vectors++;
      if (slot !== 4'd9) begin miscompares++; $display("FAIL rstmid_pre_slot got %0d want 9", slot); end
      step(1'b1, 1'b1, 1'b1, 1'b1);
      vectors += 4;
      if (slot !== 4'd0) begin miscompares++; $display("FAIL rstmid_slot got %0d want 0", slot); end
      if (locked !== 1'b0) begin miscompares++; $display("FAIL rstmid_locked got %b want 0", locked); end
      if (out_data !== 16'h0000 || out_valid !== 1'b0 || sync_err !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_outs got %h/%b/%b want 0000/0/0", out_data, out_valid, sync_err);
      end
      if (pulse_cyc.size() != 0) begin miscompares++; $display("FAIL rstmid_pulse got %0d want 0", pulse_cyc.size()); end
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, logic'($urandom_range(1)));
      vectors += 3;
      if (slot !== 4'd0) begin miscompares++; $display("FAIL rstmid_after_slot got %0d want 0", slot); end
      if (locked !== 1'b0) begin miscompares++; $display("FAIL rstmid_after_locked got %b want 0", locked); end
      if (pulse_cyc.size() != 0) begin miscompares++; $display("FAIL rstmid_after_pulses got %0d want 0", pulse_cyc.size()); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_frame(16'h1234, 1'b1, 0);
      vectors++;
      if (out_data !== 16'h1234) begin miscompares++; $display("FAIL b2b_first got %h want 1234", out_data); end
      send_frame(16'hFFFF, 1'b0, 0);
      vectors += 2;
      if (out_data !== 16'hFFFF) begin miscompares++; $display("FAIL b2b_second got %h want FFFF", out_data); end
      if (pulse_cyc.size() != 2) begin
         miscompares++; $display("FAIL b2b_pulses got %0d want 2", pulse_cyc.size());
      end else begin
         vectors++;
         if (pulse_cyc[1] - pulse_cyc[0] != 16) begin
            miscompares++; $display("FAIL b2b_spacing got %0d want 16", pulse_cyc[1] - pulse_cyc[0]);
         end
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         step(logic'($urandom_range(199) == 0), logic'($urandom_range(3) != 0),
              logic'($urandom_range(39) == 0), logic'($urandom_range(1)));
         vectors++;
         if (out_data !== m_data || out_valid !== m_ov || slot !== 4'(m_slot) ||
             locked !== m_locked || sync_err !== m_err) begin
            miscompares++;
            if (errs < 10)
               $display("FAIL random_c%0d got %h/%b/%0d/%b/%b want %h/%b/%0d/%b/%b", c,
                        out_data, out_valid, slot, locked, sync_err,
                        m_data, m_ov, m_slot, m_locked, m_err);
            errs++;
         end
      end
   endtask

   initial begin
      m_locked = 1'b0; m_slot = 0; m_frame = '0; m_data = '0; m_ov = 1'b0; m_err = 1'b0;
      test_reset();
      test_known_frame();
      test_presync();
      test_gaps();
      test_mid_sync();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tdm_demux16.md
TDM_DEMUX16 -- requirements
Module: tdm_demux16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter N_CH SHALL default to 16 and set the number of time slots per frame.
REQ-003 Parameter SEL_W SHALL default to 4 and set the slot index width, equal to log2(N_CH).
REQ-004 Port clk SHALL be an input, 1 bit wide, and be the rising-edge clock for all state.
REQ-005 Port rst SHALL be an input, 1 bit wide, and be the synchronous active-high reset.
REQ-006 Port in_bit SHALL be an input, 1 bit wide, and carry the serial TDM data bit for the current slot.
REQ-007 Port in_valid SHALL be an input, 1 bit wide, and qualify in_bit and in_sync for one cycle.
REQ-008 Port in_sync SHALL be an input, 1 bit wide, and mark the in_bit that belongs to slot 0 of a frame.
REQ-009 Port out_data SHALL be an output, N_CH bits wide, and hold the last complete frame, with bit i = slot i.
REQ-010 Port out_valid SHALL be an output, 1 bit wide, and give a 1-cycle pulse when out_data updates.
REQ-011 Port slot SHALL be an output, SEL_W bits wide, and hold the index of the next expected slot.
REQ-012 Port locked SHALL be an output, 1 bit wide, and be high once a sync has been accepted.
REQ-013 Port sync_err SHALL be an output, 1 bit wide, and give a 1-cycle pulse on a mid-frame sync.

Function
REQ-014 The block SHALL demultiplex a serial stream, produced by a 16:1 mux scanning sel 0..15, into a parallel frame.
REQ-015 The block SHALL act only on cycles with in_valid=1; in_valid=0 cycles hold all state, so gaps of any length are legal.
REQ-016 The block SHALL have two states: UNLOCKED (reset state) and LOCKED.
REQ-017 In UNLOCKED, a valid beat with in_sync=0 SHALL be discarded and slot SHALL stay 0.
REQ-018 A valid beat with in_sync=1 in UNLOCKED SHALL write in_bit to shadow[0], set slot to 1 and enter LOCKED.
REQ-019 In LOCKED, a valid beat with in_sync=0 SHALL write in_bit to shadow[slot] and increment slot.
REQ-020 A valid beat at slot=N_CH-1 SHALL load out_data with {in_bit, shadow[N_CH-2:0]} and wrap slot to 0.
REQ-021 out_valid SHALL be high in the cycle after the clock edge that samples slot N_CH-1 (1-cycle latency), and low otherwise.
REQ-022 In LOCKED, a valid beat with in_sync=1 at slot=0 SHALL be treated as a normal frame start, with no error.
REQ-023 In LOCKED, a valid beat with in_sync=1 at slot!=0 SHALL discard the partial frame (shadow cleared), write in_bit to shadow[0], set slot to 1 and pulse sync_err for 1 cycle.
REQ-024 In LOCKED, a valid beat with in_sync=0 at slot=0 SHALL be accepted as slot 0; sync is optional after lock (free-running).
REQ-025 in_sync with in_valid=0 SHALL be ignored.
REQ-026 out_data SHALL hold its value between frames and never show a partial frame.
REQ-027 A frame-completing beat and a sync cannot coincide, because a sync beat is always slot 0; the sync rule (REQ-023) governs any such beat.

Reset
REQ-028 rst=1 at a clock edge SHALL force UNLOCKED, slot=0, shadow=0, out_data=0, out_valid=0, sync_err=0 and locked=0.
REQ-029 Reset mid-frame SHALL discard the partial frame and SHALL NOT produce out_valid.
REQ-030 rst SHALL take priority over in_valid and in_sync in the same cycle.

Structure
REQ-031 N_CH and SEL_W SHALL live in a shared constants package or include, also used by the 16:1 mux blocks.
REQ-032 One sub-module, demux1x16, SHALL decode slot and in_valid into a one-hot shadow write enable.
REQ-033 The top level SHALL hold the slot counter, the lock state, the shadow register and the output register.

Verification
REQ-034 Reset, then 16 valid beats with sync on the first beat and bits 1,0,1,1,0,0,0,0,1,1,1,1,0,1,0,1 -> out_data=16'hAF0D, one out_valid pulse, slot=0.
REQ-035 Before any sync, drive 5 valid beats of 1s, then a full frame of all 0s with sync -> first 5 beats ignored, out_data=16'h0000, locked=1.
REQ-036 Drive a frame with in_valid low for 3 cycles between every beat -> same out_data as the gap-free case, exactly one out_valid pulse.
REQ-037 After 7 slots, assert sync -> sync_err pulses once, slot=1, no out_valid; the next 15 beats complete a frame containing only the new bits.
REQ-038 Assert rst at slot 9 -> all outputs 0 and locked=0 the next cycle; later beats without sync are ignored.
REQ-039 Send two back-to-back frames 16'h1234 then 16'hFFFF, with sync only on the first -> two out_valid pulses 16 beats apart, out_data=16'h1234 then 16'hFFFF.
